// File: rtl/quad_speed_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : quad_speed_sampler
//  Description : Sequences one quadrature decoder channel. It owns the
//                decoder reset, samples its count at a fixed period, and
//                publishes speed (count delta) plus a stall flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module quad_speed_sampler #(
    parameter int SAMPLE_DIV    = 100000,
    parameter int RST_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 3,
    parameter int STALL_SAMPLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        zero_req,
    input  logic [31:0] cnt_in,
    input  logic        dir_in,
    output logic        dec_rst_n,
    output logic        ready,
    output logic [31:0] speed,
    output logic        speed_valid,
    output logic        dir_out,
    output logic        stalled,
    output logic [15:0] sample_cnt
);

    localparam int c_timer_w  = $clog2(SAMPLE_DIV);
    localparam int c_hold_max = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int c_hold_w   = $clog2(c_hold_max + 1);
    localparam int c_stall_w  = $clog2(STALL_SAMPLES + 1);

    localparam logic [c_timer_w-1:0] c_timer_last  = c_timer_w'(SAMPLE_DIV - 1);
    localparam logic [c_hold_w-1:0]  c_rst_last    = c_hold_w'(RST_CYCLES - 1);
    localparam logic [c_hold_w-1:0]  c_settle_last = c_hold_w'(SETTLE_CYCLES - 1);
    localparam logic [c_stall_w-1:0] c_stall_max   = c_stall_w'(STALL_SAMPLES);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [c_hold_w-1:0]    hold_q, hold_d;
    logic [c_timer_w-1:0]   timer_q, timer_d;
    logic [31:0]            prev_cnt_q, prev_cnt_d;
    logic [c_stall_w-1:0]   stall_run_q, stall_run_d;
    logic [31:0]            speed_q, speed_d;
    logic                   speed_valid_q, speed_valid_d;
    logic                   dir_out_q, dir_out_d;
    logic                   stalled_q, stalled_d;
    logic [15:0]            sample_cnt_q, sample_cnt_d;
    logic                   dec_rst_n_q, dec_rst_n_d;
    logic                   ready_q, ready_d;

    logic [31:0]            w_delta;
    logic [c_stall_w-1:0]   w_stall_inc;

    // Modular subtraction: a decoder wrap still yields the small signed delta.
    assign w_delta     = cnt_in - prev_cnt_q;
    assign w_stall_inc = (stall_run_q == c_stall_max) ? stall_run_q
                                                      : stall_run_q + c_stall_w'(1);

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        timer_d       = timer_q;
        prev_cnt_d    = prev_cnt_q;
        stall_run_d   = stall_run_q;
        speed_d       = speed_q;
        speed_valid_d = 1'b0;
        dir_out_d     = dir_out_q;
        stalled_d     = stalled_q;
        sample_cnt_d  = sample_cnt_q;

        case (state_q)
            ST_INIT: begin
                if (hold_q == c_rst_last) begin
                    state_d = ST_SETTLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + c_hold_w'(1);
                end
            end
            ST_SETTLE: begin
                if (hold_q == c_settle_last) begin
                    state_d = ST_RUN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + c_hold_w'(1);
                end
            end
            ST_RUN: begin
                // A zero request outranks a coincident sample.
                if (zero_req) begin
                    state_d      = ST_INIT;
                    hold_d       = '0;
                    timer_d      = '0;
                    prev_cnt_d   = '0;
                    stall_run_d  = '0;
                    speed_d      = '0;
                    stalled_d    = 1'b0;
                    sample_cnt_d = '0;
                end else if (!en) begin
                    timer_d = '0;
                end else if (timer_q == c_timer_last) begin
                    timer_d       = '0;
                    speed_d       = w_delta;
                    prev_cnt_d    = cnt_in;
                    dir_out_d     = dir_in;
                    sample_cnt_d  = sample_cnt_q + 16'd1;
                    speed_valid_d = 1'b1;
                    if (w_delta == 32'd0) begin
                        stall_run_d = w_stall_inc;
                        stalled_d   = (w_stall_inc == c_stall_max);
                    end else begin
                        stall_run_d = '0;
                        stalled_d   = 1'b0;
                    end
                end else begin
                    timer_d = timer_q + c_timer_w'(1);
                end
            end
            default: begin
                state_d = ST_INIT;
                hold_d  = '0;
            end
        endcase

        dec_rst_n_d = (state_d != ST_INIT);
        ready_d     = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_INIT;
            hold_q        <= '0;
            timer_q       <= '0;
            prev_cnt_q    <= '0;
            stall_run_q   <= '0;
            speed_q       <= '0;
            speed_valid_q <= 1'b0;
            dir_out_q     <= 1'b0;
            stalled_q     <= 1'b0;
            sample_cnt_q  <= '0;
            dec_rst_n_q   <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            timer_q       <= timer_d;
            prev_cnt_q    <= prev_cnt_d;
            stall_run_q   <= stall_run_d;
            speed_q       <= speed_d;
            speed_valid_q <= speed_valid_d;
            dir_out_q     <= dir_out_d;
            stalled_q     <= stalled_d;
            sample_cnt_q  <= sample_cnt_d;
            dec_rst_n_q   <= dec_rst_n_d;
            ready_q       <= ready_d;
        end
    end

    assign dec_rst_n   = dec_rst_n_q;
    assign ready       = ready_q;
    assign speed       = speed_q;
    assign speed_valid = speed_valid_q;
    assign dir_out     = dir_out_q;
    assign stalled     = stalled_q;
    assign sample_cnt  = sample_cnt_q;

endmodule
`default_nettype wire

// File: doc/quad_speed_sampler.md
Name: quad_speed_sampler

Overview:
Controller that sequences one quadrature decoder channel. It owns the decoder's active-low reset, which is used for power-up init and for zero/home requests. During normal running it samples the decoder's 32-bit signed count at a fixed period and publishes the per-period delta as speed. It also flags a stalled motor. It sits between the decoder and the motor-control/telemetry logic.

Parameters:
SAMPLE_DIV, 100000, clk cycles per speed sample (1 ms at 100 MHz); minimum 4.
RST_CYCLES, 4, cycles dec_rst_n is held low on init/zero; minimum 1.
SETTLE_CYCLES, 3, cycles after dec_rst_n release before sampling resumes (covers decoder 2-stage input sync); minimum 1.
STALL_SAMPLES, 8, consecutive zero-delta samples before stalled asserts; minimum 1.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
en  in  1  sampling enable; timer frozen at 0 when low
zero_req  in  1  single-cycle request to zero the decoder
cnt_in  in  32  decoder count, two's complement, wraps mod 2^32
dir_in  in  1  decoder direction, passed through registered
dec_rst_n  out  1  drives decoder rst (active-low)
ready  out  1  high only in RUN
speed  out  32  signed count delta over last sample period
speed_valid  out  1  one-cycle pulse when speed updates
dir_out  out  1  dir_in registered at each sample
stalled  out  1  motor-stalled flag
sample_cnt  out  16  number of samples since last zero, wraps

Behaviour:
- Reset (async, rst=0): state=INIT, dec_rst_n=0, ready=0, speed=0, speed_valid=0, dir_out=0, stalled=0, sample_cnt=0, timer=0, prev_cnt=0, stall_run=0, hold counter=0.
- States: INIT -> SETTLE -> RUN; RUN -> INIT on zero_req.
- INIT: dec_rst_n=0 for exactly RST_CYCLES cycles, then go to SETTLE. On entry from RUN, clear speed, stalled, sample_cnt, prev_cnt, stall_run and timer in the same edge.
- SETTLE: dec_rst_n=1 for exactly SETTLE_CYCLES cycles, then go to RUN.
- RUN: ready=1, dec_rst_n=1.
  - Timer counts 0..SAMPLE_DIV-1 while en=1 and holds at 0 while en=0.
  - At the edge where the timer equals SAMPLE_DIV-1:
    - speed <= cnt_in - prev_cnt, 32-bit modular subtraction read as signed; decoder wrap therefore yields the correct small delta.
    - prev_cnt <= cnt_in; dir_out <= dir_in; sample_cnt +1 (wraps); timer <= 0.
    - speed_valid=1 for the following cycle only.
- Stall logic, evaluated at each sample:
  - delta==0: stall_run increments, saturating at STALL_SAMPLES; stalled=1 when stall_run reaches STALL_SAMPLES.
  - delta!=0: stall_run=0 and stalled=0 on the same edge that updates speed.
- Latency: speed/speed_valid are registered one cycle after the terminal timer cycle. The first sample after entering RUN occurs SAMPLE_DIV enabled cycles later.
- Priority rules:
  - zero_req in RUN on the same cycle as a timer terminal: zero wins; no sample, no speed_valid.
  - zero_req in INIT/SETTLE is ignored (not queued).
  - en dropping mid-period resets the timer to 0; the partial period is discarded.
- Re-assertion of rst at any time returns everything to reset values immediately, including dec_rst_n=0.
- speed_valid never asserts outside RUN.

Test Plan:
Use SAMPLE_DIV=10, RST_CYCLES=4, SETTLE_CYCLES=3, STALL_SAMPLES=3.
- Power-up: release rst -> dec_rst_n low 4 cycles, high with ready=0 for 3 cycles, then ready=1; no speed_valid before 10 enabled RUN cycles.
- Forward speed: en=1, cnt_in ramps 0->25 over the first period, then +7 per period -> speed_valid every 10 cycles; speed=25, then 7, 7; sample_cnt=1,2,3.
- Reverse and wrap: prev_cnt=0x00000002, cnt_in=0xFFFFFFFD at the sample -> speed=0xFFFFFFFB (-5); dir_out follows dir_in=0.
- Stall: cnt_in held constant -> stalled=1 after the 3rd zero-delta sample; cnt_in+1 at the next sample -> stalled=0 with that speed_valid.
- Zero collision: zero_req on the timer-terminal cycle -> no speed_valid; dec_rst_n low 4 cycles; speed=0, sample_cnt=0, stalled=0; zero_req pulsed during SETTLE is ignored.
- Async reset mid-RUN: rst low between clock edges -> all outputs reset immediately without a clock edge, dec_rst_n=0.
